// File: rtl/i2s_tx.sv
// ============================================================================
// i2s_tx -- playback-side I2S transmitter (codec is LR-clock master, this
// block is slave).
//
// Packed stereo words {left, right} are queued in an internal synchronous,
// non-showahead FIFO. Each falling edge of the codec LR clock pops one word
// (or substitutes silence on underflow). That word is then serialised
// MSB-first onto dacdat: the left half goes out in the low LRC slot, and the
// right half goes out in the high LRC slot. Slots longer than DATA_WIDTH/2
// bit clocks are padded with 0. Shorter slots are truncated, so the LSBs are
// lost. A falling LRC edge always resynchronises to the MSB of a new word.
//
// Optional feature (macro I2S_TX_HOLD_LAST_EN):
//   defined   - on underflow the previously transmitted word is repeated
//   undefined - on underflow silence (all zeros) is transmitted
//
// Parameters:
//   DATA_WIDTH  packed stereo word width (even, >= 4)
//   ADDR_WIDTH  FIFO address bits, depth = 2**ADDR_WIDTH
//
// Ports:
//   bclk               in   bit clock, the only clock (posedge)
//   reset_n            in   asynchronous active-low reset
//   daclrc             in   codec LR clock, low = left slot, high = right slot
//   dacfifo_write      in   write strobe, one word per cycle while high
//   dacfifo_writedata  in   word to enqueue
//   dacfifo_full       out  FIFO full, writes ignored while high
//   dacfifo_usedw      out  FIFO occupancy 0..2**ADDR_WIDTH
//   dacdat             out  serial DAC data
//   dac_underflow      out  one-cycle pulse: frame start found FIFO empty
// ============================================================================
module i2s_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  bclk,
    input  logic                  reset_n,
    input  logic                  daclrc,
    input  logic                  dacfifo_write,
    input  logic [DATA_WIDTH-1:0] dacfifo_writedata,
    output logic                  dacfifo_full,
    output logic [ADDR_WIDTH:0]   dacfifo_usedw,
    output logic                  dacdat,
    output logic                  dac_underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int HALF  = DATA_WIDTH / 2;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LTOP = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LEND = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_RTOP = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_REND = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEFT,
        ST_LEFT_PAD,
        ST_RIGHT,
        ST_RIGHT_PAD
    } state_t;

    // ------------------------------------------------------------------
    // LR clock synchroniser and edge detection
    // ------------------------------------------------------------------
    logic r_lrc_r0;
    logic r_lrc_r1;
    logic w_fall;
    logic w_rise;

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_lrc_r0 <= 1'b1;
            r_lrc_r1 <= 1'b1;
        end else begin
            r_lrc_r0 <= daclrc;
            r_lrc_r1 <= r_lrc_r0;
        end
    end

    // Both edges act in the cycle they are seen. Together with the two
    // synchroniser flops and the registered dacdat, this gives three bclk
    // posedges from a pin edge to the first data bit.
    assign w_fall = r_lrc_r1 & ~r_lrc_r0;
    assign w_rise = ~r_lrc_r1 & r_lrc_r0;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_usedw;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_pop;

    // Occupancy can only reach DEPTH, so its top bit alone marks full.
    assign w_full  = r_usedw[ADDR_WIDTH];
    assign w_empty = (r_usedw == '0);
    assign w_wr_en = dacfifo_write & ~w_full;
    assign w_pop   = w_fall & ~w_empty;

    // Storage array has no reset so it can map onto block RAM.
    always_ff @(posedge bclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= dacfifo_writedata;
        end
    end

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr_en, w_pop})
                2'b10:   r_usedw <= r_usedw + 1'b1;
                2'b01:   r_usedw <= r_usedw - 1'b1;
                default: r_usedw <= r_usedw;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame word register (also the FIFO's registered read port)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_shreg;

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg <= '0;
        end else if (w_fall) begin
`ifdef I2S_TX_HOLD_LAST_EN
            // Underflow keeps the last word so the previous sample repeats.
            if (w_pop) begin
                r_shreg <= r_mem[r_rd_ptr];
            end
`else
            r_shreg <= w_pop ? r_mem[r_rd_ptr] : '0;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Serialiser state machine
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_next;
    logic             r_dacdat;
    logic             w_dacdat_next;
    logic             r_underflow;

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_dacdat    <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_dacdat    <= w_dacdat_next;
            r_underflow <= w_fall & w_empty;
        end
    end

    // The cycle in which an LRC edge is acted upon always drives a 0.
    // Data starts on the following posedge.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_dacdat_next  = 1'b0;

        if (w_fall) begin
            // Frame start from any state; truncates whatever was in flight.
            w_state_next   = ST_LEFT;
            w_bit_cnt_next = CNT_LTOP;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_IDLE;
                end
                ST_LEFT: begin
                    if (w_rise) begin
                        // Early right slot: drop the remaining left bits.
                        w_state_next   = ST_RIGHT;
                        w_bit_cnt_next = CNT_RTOP;
                    end else begin
                        w_dacdat_next = r_shreg[r_bit_cnt];
                        if (r_bit_cnt == CNT_LEND) begin
                            w_state_next = ST_LEFT_PAD;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt - 1'b1;
                        end
                    end
                end
                ST_LEFT_PAD: begin
                    if (w_rise) begin
                        w_state_next   = ST_RIGHT;
                        w_bit_cnt_next = CNT_RTOP;
                    end
                end
                ST_RIGHT: begin
                    // A rise here is a glitch or misframe and is ignored.
                    w_dacdat_next = r_shreg[r_bit_cnt];
                    if (r_bit_cnt == CNT_REND) begin
                        w_state_next = ST_RIGHT_PAD;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt - 1'b1;
                    end
                end
                ST_RIGHT_PAD: begin
                    w_state_next = ST_RIGHT_PAD;
                end
                default: begin
                    w_state_next   = ST_IDLE;
                    w_bit_cnt_next = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dacfifo_full  = w_full;
    assign dacfifo_usedw = r_usedw;
    assign dacdat        = r_dacdat;
    assign dac_underflow = r_underflow;

endmodule
